rgb_pwm_driver: RTL and testbench

RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

---
 rtl/rgb_pwm_driver.sv | 75 +++++++
 tb/tb_rgb_pwm_driver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM driver with prescaled step clock.
// Duty is shadowed and reloaded only at frame boundaries.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] rgb_in,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        frame_start,
  output logic [23:0] duty_active
);

  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0] CNT_LAST = 8'd254;

  logic [PW-1:0] pre_cnt;
  logic [7:0]    pwm_cnt;
  logic          tick;
  logic          frame_end;

  assign tick      = (pre_cnt == PRE_LAST);
  assign frame_end = tick & (pwm_cnt == CNT_LAST);

  // Pulse marks the cycle whose closing edge loads the shadow.
  assign frame_start = enable & frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (!enable || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (!enable || frame_end) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Disabled: track the request so re-enable starts on fresh duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_active <= '0;
    end else if (!enable || frame_end) begin
      duty_active <= rgb_in;
    end
  end

  // Counter tops out at 254, so duty 255 never drops a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_r <= 1'b0;
      pwm_g <= 1'b0;
      pwm_b <= 1'b0;
    end else begin
      pwm_r <= enable & (pwm_cnt < duty_active[23:16]);
      pwm_g <= enable & (pwm_cnt < duty_active[15:8]);
      pwm_b <= enable & (pwm_cnt < duty_active[7:0]);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver at PRESCALE 1 and 4.
// Expected counts are hand-derived per frame.
module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [23:0] rgb_in;
  logic        pwm_r, pwm_g, pwm_b, frame_start;
  logic [23:0] duty_active;

  logic        rst4;
  logic        enable4;
  logic [23:0] rgb4;
  logic        pwm_r4, pwm_g4, pwm_b4, fs4;
  logic [23:0] duty4;

  int vectors = 0;
  int fails = 0;
  int cr, cg, cb, cf;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .rgb_in(rgb_in), .pwm_r(pwm_r), .pwm_g(pwm_g),
    .pwm_b(pwm_b), .frame_start(frame_start),
    .duty_active(duty_active)
  );

  rgb_pwm_driver #(.PRESCALE(4)) u4 (
    .clk(clk), .rst_n(rst4), .enable(enable4),
    .rgb_in(rgb4), .pwm_r(pwm_r4), .pwm_g(pwm_g4),
    .pwm_b(pwm_b4), .frame_start(fs4),
    .duty_active(duty4)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cr = 0; cg = 0; cb = 0; cf = 0;
  endtask

  task automatic run(input int n, input bit four);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (four) begin
        cr += int'(pwm_r4); cg += int'(pwm_g4);
        cb += int'(pwm_b4); cf += int'(fs4);
      end else begin
        cr += int'(pwm_r); cg += int'(pwm_g);
        cb += int'(pwm_b); cf += int'(frame_start);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; rgb_in = 24'hFF0080;
    rst4 = 1'b0; enable4 = 1'b1; rgb4 = 24'h010001;
    #1;
    check("rst_pwm", 32'({pwm_r, pwm_g, pwm_b}), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_duty", 32'(duty_active), 32'd0);
    check("rst4_duty", 32'(duty4), 32'd0);

    // Frame 1 after reset runs at duty 0
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("f1_fs0", 32'(frame_start), 32'd0);
    clr();
    run(254, 1'b0);
    check("f1_fs_now", 32'(frame_start), 32'd1);
    check("f1_fs_cnt", 32'(cf), 32'd1);
    check("f1_high", 32'(cr + cg + cb), 32'd0);
    check("f1_duty", 32'(duty_active), 32'd0);
    run(1, 1'b0);
    check("f1_load", 32'(duty_active), 32'hFF0080);
    check("f1_fs_off", 32'(frame_start), 32'd0);

    // Frame 2, request changes mid-frame
    clr();
    run(100, 1'b0);
    rgb_in = 24'h000000;
    check("f2_hold", 32'(duty_active), 32'hFF0080);
    run(155, 1'b0);
    check("f2_r", 32'(cr), 32'd255);
    check("f2_g", 32'(cg), 32'd0);
    check("f2_b", 32'(cb), 32'd128);
    check("f2_fs", 32'(cf), 32'd1);
    check("f2_load", 32'(duty_active), 32'h000000);

    clr();
    rgb_in = 24'h0000FF;
    run(255, 1'b0);
    check("f3_high", 32'(cr + cg + cb), 32'd0);
    check("f3_load", 32'(duty_active), 32'h0000FF);

    // Disable mid-frame with pwm_b high
    run(50, 1'b0);
    check("pre_dis_b", 32'(pwm_b), 32'd1);
    clr();
    enable = 1'b0;
    #1;
    check("dis_fs", 32'(frame_start), 32'd0);
    run(1, 1'b0);
    check("dis_pwm", 32'({pwm_r, pwm_g, pwm_b}), 32'd0);
    check("dis_duty", 32'(duty_active), 32'h0000FF);
    rgb_in = 24'h123456;
    run(1, 1'b0);
    check("dis_track", 32'(duty_active), 32'h123456);
    rgb_in = 24'h0000FF;
    run(8, 1'b0);
    check("dis_quiet", 32'(cr + cg + cb + cf), 32'd0);
    check("dis_duty2", 32'(duty_active), 32'h0000FF);
    enable = 1'b1;
    clr();
    run(255, 1'b0);
    check("en_b", 32'(cb), 32'd255);
    check("en_rg", 32'(cr + cg), 32'd0);
    check("en_fs", 32'(cf), 32'd1);

    // Near-boundary duties
    rgb_in = 24'hFE0100;
    run(255, 1'b0);
    check("fe_load", 32'(duty_active), 32'hFE0100);
    clr();
    run(1, 1'b0);
    check("fe_g_first", 32'(pwm_g), 32'd1);
    run(254, 1'b0);
    check("fe_r", 32'(cr), 32'd254);
    check("fe_r_last", 32'(pwm_r), 32'd0);
    check("fe_g", 32'(cg), 32'd1);
    check("fe_b", 32'(cb), 32'd0);

    // Asynchronous reset mid-frame
    run(10, 1'b0);
    check("ar_pre_r", 32'(pwm_r), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_r", 32'(pwm_r), 32'd0);
    check("ar_fs", 32'(frame_start), 32'd0);
    check("ar_duty", 32'(duty_active), 32'd0);
    rgb_in = 24'hFF0080;
    #1;
    rst_n = 1'b1;
    clr();
    run(254, 1'b0);
    check("ar_f1_high", 32'(cr + cg + cb), 32'd0);
    check("ar_f1_fs", 32'(frame_start), 32'd1);
    run(1, 1'b0);
    check("ar_load", 32'(duty_active), 32'hFF0080);
    clr();
    run(255, 1'b0);
    check("ar_f2", 32'({cr[15:0], cg[7:0], cb[7:0]}),
          32'h00FF_0080);

    // PRESCALE=4 instance
    @(negedge clk);
    rst4 = 1'b1;
    clr();
    run(1019, 1'b1);
    check("p4_fs_now", 32'(fs4), 32'd1);
    check("p4_fs_cnt", 32'(cf), 32'd1);
    check("p4_f1_high", 32'(cr + cg + cb), 32'd0);
    run(1, 1'b1);
    check("p4_load", 32'(duty4), 32'h010001);
    check("p4_fs_off", 32'(fs4), 32'd0);
    clr();
    run(4, 1'b1);
    check("p4_r_on", 32'(pwm_r4), 32'd1);
    check("p4_r4", 32'(cr), 32'd4);
    run(1, 1'b1);
    check("p4_r_off", 32'(pwm_r4), 32'd0);
    run(1015, 1'b1);
    check("p4_r", 32'(cr), 32'd4);
    check("p4_g", 32'(cg), 32'd0);
    check("p4_b", 32'(cb), 32'd4);
    check("p4_fs", 32'(cf), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
